uga_uart_rx_ctrl: RTL and testbench
===================================

// Module: uga_uart_rx_ctrl
// PURPOSE
// Sequencer/buffer around the UART RX deserialiser (8x oversampling, tick-driven).
// Generates the oversampling tick from a programmable divider and gates the
// receiver's start-bit enable. Captures each completed byte into a small FIFO
// with a valid/ready drain port. Reports overflow, aborted frames and line-idle gaps.
// PARAMETERS
// DEPTH       4   FIFO entries; power of 2, >=2
// DIV_W       16  width of cfg_divisor
// FRAME_TICKS 96  ticks allowed from start-bit detect to byte done (12 bit times)
// IDLE_BITS   4   idle bit times after the last byte before idle_timeout fires
// PORTS
// clk           in   1       system clock
// rst           in   1       async reset, active high
// cfg_enable    in   1       receive enable
// cfg_divisor   in   DIV_W   clk cycles per tick (tick = 8x baud)
// tick          out  1       oversampling strobe to receiver
// rx_en         out  1       to receiver rx_data_valid (start-bit acceptance)
// rx_data       in   8       receiver byte
// rx_data_ready in   1       receiver ready; 1->0 at start bit, 0->1 with byte
// m_data        out  8       FIFO head
// m_valid       out  1       FIFO not empty
// m_ready       in   1       consumer accepts head
// fifo_level    out  $clog2(DEPTH)+1  occupied entries
// ovf           out  1       sticky: byte dropped, FIFO full
// ovf_clr       in   1       clears ovf
// abort_pulse   out  1       1-cycle: frame timed out
// idle_timeout  out  1       1-cycle: line idle after last byte
// BEHAVIOUR
// - Async reset: all outputs 0, counters 0, FIFO empty, state OFF.
// - Divider: cnt runs 0..cfg_divisor-1 while cfg_enable. tick=1 for one cycle at terminal count.
//   cfg_divisor 0 or 1 gives tick every cycle. A divisor change takes effect at the next wrap.
//   cnt and tick are held at 0 when cfg_enable=0.
// - rdy_q = rx_data_ready delayed 1 clk. fall = rdy_q&~rx_data_ready. rise = ~rdy_q&rx_data_ready.
// - FSM: OFF, SYNC, ARM, BUSY.
//   OFF : cfg_enable -> SYNC.
//   SYNC: waits out any frame left over from reset; rx_data_ready=1 -> ARM;
//         ~cfg_enable -> OFF.
//   ARM : fall -> BUSY (frame timer cleared); ~cfg_enable & ~fall -> OFF.
//   BUSY: rise -> ARM (OFF if ~cfg_enable). Frame timer counts ticks.
//         Timer reaching FRAME_TICKS -> ARM with abort_pulse=1; covers a false start.
// - rx_en = cfg_enable & (state in ARM,BUSY) & (fifo_level<DEPTH). Combinational.
// - Capture: rise while in ARM or BUSY -> push rx_data in that same cycle. rx_data is valid
//   with the rising ready. A byte in flight when cfg_enable drops is still captured.
// - FIFO: m_data=mem[rd_ptr]; pop on m_valid&m_ready. Pointers wrap modulo DEPTH.
//   Push at full is accepted only if a pop occurs in the same cycle; fifo_level is then unchanged.
//   Push at full with no pop drops the byte and sets ovf.
//   Push and pop at empty: byte stored, m_valid=1 the next cycle; no bypass. Latency rise->m_valid = 1 clk.
// - ovf: set wins over ovf_clr in the same cycle.
// - Idle timer: cleared and armed by each capture. In ARM it counts ticks.
//   At IDLE_BITS*8 ticks: idle_timeout=1 for one cycle, then disarmed (one per gap).
//   fall disarms the timer.
// - Reset mid-frame: FIFO contents lost. After release the FSM takes OFF->SYNC, and the
//   partial frame's completion is not captured.
// TESTING
// - cfg_divisor=4, enable: tick high every 4th clk; divisor 0 -> tick every clk; disable -> tick 0.
// - Frame 0xA5: ready 1->0 then 0->1 with rx_data=A5.
//   Expect m_valid next clk, m_data=A5; m_ready pop -> level 0.
// - DEPTH=4, m_ready=0, send 01..04: rx_en drops at level 4.
//   Force a 5th rise with 05: ovf=1, level=4, head=01. ovf_clr -> ovf=0.
// - Full FIFO, 5th rise coincident with pop: level stays 4, drained order 02,03,04,05, ovf=0.
// - ready falls and stays 0 for 96 ticks: abort_pulse once, state ARM, nothing pushed.
// - Byte captured, then 32 ticks of no fall: exactly one idle_timeout. rst asserted mid-frame:
//   outputs 0 at once; frame completing post-reset not pushed.

Source files
------------

// File: rtl/uga_uart_rx_ctrl_if.sv
// Drain port of the UART RX byte buffer: FIFO head with valid/ready handshake.
interface uga_uart_rx_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uga_uart_rx_ctrl.sv
// UART RX sequencer/buffer: oversampling tick divider, start-bit gating,
// byte capture FIFO with valid/ready drain, overflow/abort/idle reporting.
module uga_uart_rx_ctrl #(
  parameter int DEPTH       = 4,
  parameter int DIV_W       = 16,
  parameter int FRAME_TICKS = 96,
  parameter int IDLE_BITS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_enable,
  input  logic [DIV_W-1:0]           cfg_divisor,
  output logic                       tick,
  output logic                       rx_en,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_data_ready,
  uga_uart_rx_ctrl_if.master         m_if,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic                       abort_pulse,
  output logic                       idle_timeout
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int FW     = $clog2(FRAME_TICKS + 1);
  localparam int IDLE_T = IDLE_BITS * 8;
  localparam int IW     = $clog2(IDLE_T + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_OFF, S_SYNC, S_ARM, S_BUSY} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  cnt, div_q, div_term;
  logic              tick_q;
  logic              rdy_q, fall, rise;
  logic [FW-1:0]     frame_cnt;
  logic [IW-1:0]     idle_cnt;
  logic              idle_armed;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              active, push, pop, full, push_ok;

  // Terminal count of the divider; divisor 0 or 1 both mean "every cycle".
  always_comb begin
    div_term = (div_q <= DIV_W'(1)) ? '0 : div_q - DIV_W'(1);
  end

  // Tick divider; the divisor is sampled only at wrap so changes never shorten a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (!cfg_enable) begin
      cnt    <= '0;
      div_q  <= cfg_divisor;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt == div_term);
      if (cnt == div_term) begin
        cnt   <= '0;
        div_q <= cfg_divisor;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign tick = tick_q & cfg_enable;

  // Ready edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= rx_data_ready;
  end

  assign fall   = rdy_q & ~rx_data_ready;
  assign rise   = ~rdy_q & rx_data_ready;
  assign active = (state == S_ARM) || (state == S_BUSY);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OFF;
    else     state <= state_nx;
  end

  // FSM next state and frame-abort strobe.
  always_comb begin
    state_nx    = state;
    abort_pulse = 1'b0;
    unique case (state)
      S_OFF:  if (cfg_enable) state_nx = S_SYNC;
      S_SYNC: begin
        if (!cfg_enable)        state_nx = S_OFF;
        else if (rx_data_ready) state_nx = S_ARM;
      end
      S_ARM: begin
        if (fall)             state_nx = S_BUSY;
        else if (!cfg_enable) state_nx = S_OFF;
      end
      S_BUSY: begin
        if (rise) begin
          state_nx = cfg_enable ? S_ARM : S_OFF;
        end else if (tick && frame_cnt == FW'(FRAME_TICKS - 1)) begin
          state_nx    = S_ARM;
          abort_pulse = 1'b1;
        end
      end
      default: state_nx = S_OFF;
    endcase
  end

  // Frame timer: cleared on start-bit detect, counts ticks while a frame is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            frame_cnt <= '0;
    else if (state == S_ARM && fall)    frame_cnt <= '0;
    else if (state == S_BUSY && tick)   frame_cnt <= frame_cnt + FW'(1);
  end

  assign rx_en   = cfg_enable & active & (fifo_level < FULL_LVL);
  assign push    = rise & active;
  assign full    = (fifo_level == FULL_LVL);
  assign pop     = m_if.m_valid & m_if.m_ready;
  assign push_ok = push & (~full | pop);

  assign m_if.m_data  = mem[rd_ptr];
  assign m_if.m_valid = (fifo_level != '0);

  // Byte FIFO storage and pointers; a push at full survives only alongside a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= rx_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky overflow; a new drop in the same cycle beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ovf <= 1'b0;
    else if (push & full & ~pop) ovf <= 1'b1;
    else if (ovf_clr)            ovf <= 1'b0;
  end

  // Idle-gap timer: armed by each capture, fires once per gap, disarmed by a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt     <= '0;
      idle_armed   <= 1'b0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= 1'b0;
      if (push) begin
        idle_cnt   <= '0;
        idle_armed <= 1'b1;
      end else if (fall) begin
        idle_armed <= 1'b0;
      end else if (idle_armed && state == S_ARM && tick) begin
        if (idle_cnt == IW'(IDLE_T - 1)) begin
          idle_timeout <= 1'b1;
          idle_armed   <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uga_uart_rx_ctrl.sv
// Scoreboard bench for uga_uart_rx_ctrl.
module tb_uga_uart_rx_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_enable;
  logic [15:0] cfg_divisor;
  logic        tick, rx_en;
  logic [7:0]  rx_data;
  logic        rx_data_ready;
  logic [2:0]  fifo_level;
  logic        ovf, ovf_clr, abort_pulse, idle_timeout;

  uga_uart_rx_ctrl_if bus ();

  uga_uart_rx_ctrl #(.DEPTH(4), .DIV_W(16), .FRAME_TICKS(96), .IDLE_BITS(4)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_divisor(cfg_divisor),
    .tick(tick), .rx_en(rx_en), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .m_if(bus.master), .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr),
    .abort_pulse(abort_pulse), .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_abort = 0;
  int n_idle  = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Event counters and drain scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (abort_pulse)  n_abort++;
    if (idle_timeout) n_idle++;
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (sb.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else chk("sb_data", {24'd0, bus.m_data}, {24'd0, sb.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] b, input logic pop_at_rise);
    @(posedge clk); #1 rx_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_data_ready = 1'b1; rx_data = b; bus.m_ready = pop_at_rise;
    @(posedge clk); #1 bus.m_ready = 1'b0;
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1 bus.m_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.m_ready = 1'b0;
  endtask

  initial begin
    int last, cnt, snap;
    rst = 1'b1; cfg_enable = 1'b1; cfg_divisor = 16'd4;
    rx_data = 8'h00; rx_data_ready = 1'b1; bus.m_ready = 1'b0; ovf_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tick", tick, 0);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_flags", {abort_pulse, idle_timeout}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Divider at 4
    repeat (4) @(posedge clk);
    last = -1; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick) begin
        if (last >= 0) chk("tick_gap", i - last, 4);
        last = i; cnt++;
      end
    end
    chk("tick_cnt4", cnt, 4);
    chk("armed_rx_en", rx_en, 1);

    // Divisor 0 after next wrap
    cfg_divisor = 16'd0;
    repeat (8) @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (tick) cnt++; end
    chk("tick_cnt0", cnt, 8);

    // Disabled
    @(posedge clk); #1 cfg_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (tick) cnt++; end
    chk("tick_off", cnt, 0);
    chk("off_rx_en", rx_en, 0);
    @(posedge clk); #1 cfg_enable = 1'b1; cfg_divisor = 16'd4;
    repeat (6) @(posedge clk);

    // Single frame A5 and latency
    snap = n_idle;
    sb.push_back(8'hA5);
    @(posedge clk); #1 rx_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_data_ready = 1'b1; rx_data = 8'hA5;
    @(negedge clk);
    chk("pre_valid", bus.m_valid, 0);
    @(negedge clk);
    chk("a5_valid", bus.m_valid, 1);
    chk("a5_data", bus.m_data, 8'hA5);
    chk("a5_level", fifo_level, 1);
    drain(1);
    @(negedge clk);
    chk("a5_level0", fifo_level, 0);

    // Idle gap: exactly one idle_timeout
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("idle_once", n_idle - snap, 1);

    // Fill to full
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i));
      send_frame(8'(i), 1'b0);
    end
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_rx_en", rx_en, 0);

    // Forced 5th byte dropped
    send_frame(8'h05, 1'b0);
    @(negedge clk);
    chk("ovf_set", ovf, 1);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_head", bus.m_data, 8'h01);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", ovf, 0);

    // Push at full with simultaneous pop
    sb.push_back(8'h05);
    send_frame(8'h05, 1'b1);
    @(negedge clk);
    chk("pp_level", fifo_level, 4);
    chk("pp_ovf", ovf, 0);
    chk("pp_head", bus.m_data, 8'h02);
    drain(6);
    @(negedge clk);
    chk("drain_level", fifo_level, 0);
    chk("drain_valid", bus.m_valid, 0);
    chk("sb_empty1", sb.size(), 0);

    // False start: abort once after 96 ticks
    snap = n_abort;
    @(posedge clk); #1 rx_data_ready = 1'b0;
    repeat (420) @(posedge clk);
    @(negedge clk);
    chk("abort_once", n_abort - snap, 1);
    chk("abort_level", fifo_level, 0);
    chk("abort_arm", rx_en, 1);
    @(posedge clk); #1 cfg_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_data_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 cfg_enable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reenable_rx_en", rx_en, 1);
    chk("reenable_level", fifo_level, 0);

    // Reset mid-frame
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", bus.m_valid, 1);
    sb.delete();
    @(posedge clk); #1 rx_data_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_rx_en", rx_en, 0);
    chk("mid_rst_tick", tick, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_data_ready = 1'b1; rx_data = 8'h77;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", bus.m_valid, 0);
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_rx_en", rx_en, 1);
    chk("sb_empty2", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
